// File: rtl/bcd_time_converter_pkg.sv
// Shared types and elaboration helpers for the sequential binary-to-BCD time converter.
package bcd_time_converter_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } stateT;

  typedef logic [3:0] bcdDigitT;

  // Saturates rather than wrapping so oversized DIGITS still passes the range check.
  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      if (r > 64'd1844674407370955161) return 64'hFFFF_FFFF_FFFF_FFFF;
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble nibble correction: add 3 to any digit of 5 or more before the next shift.
module bcd_digit_adjust
  import bcd_time_converter_pkg::*;
(
  input  logic [3:0] digIn,
  output logic [3:0] digOut
);

  bcdDigitT dig;

  assign dig    = digIn;
  assign digOut = (dig >= 4'd5) ? dig + 4'd3 : dig;

endmodule

// File: rtl/bcd_time_converter.sv
// Iterative shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// Optional leading-zero blank mask enabled by defining BCD_LEADING_BLANK_EN.
module bcd_time_converter
  import bcd_time_converter_pkg::*;
#(
  parameter int BIN_WIDTH = 26,
  parameter int DIGITS    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  bin_in,
  output logic                  busy,
  output logic                  done,
`ifdef BCD_LEADING_BLANK_EN
  output logic [DIGITS-1:0]     blank_mask,
`endif
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int CNT_W = $clog2(BIN_WIDTH + 1);
  localparam int ACC_W = 4 * DIGITS;

  if (BIN_WIDTH < 1 || BIN_WIDTH > 62 ||
      ((64'd1 << BIN_WIDTH) - 64'd1) >= pow10(DIGITS)) begin : gIllegal
    $error("bcd_time_converter: 2^BIN_WIDTH-1 must be below 10^DIGITS");
  end

  stateT                state;
  logic [BIN_WIDTH-1:0] shReg;
  logic [BIN_WIDTH-1:0] shNext;
  logic [ACC_W-1:0]     acc;
  logic [ACC_W-1:0]     adj;
  logic [ACC_W-1:0]     accNext;
  logic [CNT_W-1:0]     cnt;
  logic [ACC_W+BIN_WIDTH-1:0] shifted;

  for (genvar d = 0; d < DIGITS; d++) begin : gDig
    bcd_digit_adjust uAdj (
      .digIn  (acc[4*d +: 4]),
      .digOut (adj[4*d +: 4])
    );
  end

  // Adjusted accumulator and shift register move left together as one word.
  assign shifted = {adj, shReg} << 1;
  assign accNext = shifted[ACC_W+BIN_WIDTH-1:BIN_WIDTH];
  assign shNext  = shifted[BIN_WIDTH-1:0];

`ifdef BCD_LEADING_BLANK_EN
  logic [DIGITS-1:0] maskNext;
  logic              zeroAbove;

  // Digit 0 is never blanked so a zero value still shows one "0".
  always_comb begin
    maskNext  = '0;
    zeroAbove = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zeroAbove   = zeroAbove & (accNext[4*i +: 4] == 4'd0);
      maskNext[i] = zeroAbove;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shReg   <= '0;
      acc     <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd_out <= '0;
`ifdef BCD_LEADING_BLANK_EN
      blank_mask <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shReg <= bin_in;
            acc   <= '0;
            cnt   <= CNT_W'(BIN_WIDTH);
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          acc   <= accNext;
          shReg <= shNext;
          cnt   <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            bcd_out <= accNext;
`ifdef BCD_LEADING_BLANK_EN
            blank_mask <= maskNext;
`endif
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_time_converter.sv
// Directed self-checking bench for bcd_time_converter (BIN_WIDTH=26, DIGITS=8).
module tb_bcd_time_converter;

  logic        clk;
  logic        rst;
  logic        start;
  logic [25:0] bin_in;
  logic        busy;
  logic        done;
  logic [31:0] bcd_out;
`ifdef BCD_LEADING_BLANK_EN
  logic [7:0]  blank_mask;
`endif

  int passCnt  = 0;
  int totalCnt = 0;

  bcd_time_converter #(.BIN_WIDTH(26), .DIGITS(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
`ifdef BCD_LEADING_BLANK_EN
    .blank_mask (blank_mask),
`endif
    .bcd_out (bcd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    totalCnt++;
    assert (got === exp) passCnt++;
    else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic chkMask(input string tag, input logic [7:0] exp);
`ifdef BCD_LEADING_BLANK_EN
    chk(tag, 64'(blank_mask), 64'(exp));
`else
    if (exp === 8'hxx) $display("unused %s", tag);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepting edge is cycle 0 here; returns edges until done and busy samples seen.
  task automatic runConv(input logic [25:0] v, output int cyc, output int busyCnt);
    bin_in = v;
    start  = 1'b1;
    tick();
    start   = 1'b0;
    cyc     = 0;
    busyCnt = busy ? 1 : 0;
    while (!done && cyc < 40) begin
      tick();
      cyc++;
      if (busy) busyCnt++;
    end
  endtask

  initial begin
    int cyc, busyCnt, doneCnt, lastDone;
    int doneAt[$];

    rst = 1'b1; start = 1'b0; bin_in = '0;
    tick(); tick();
    chk("rst_bcd",  64'(bcd_out), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chkMask("rst_mask", 8'h00);
    rst = 1'b0;
    tick();

    // Zero input
    runConv(26'd0, cyc, busyCnt);
    chk("zero_latency", 64'(cyc), 64'd26);
    chk("zero_bcd", 64'(bcd_out), 64'h0);
    chk("zero_busy_in_done", 64'(busy), 64'h0);
    chkMask("zero_mask", 8'hFE);
    tick();
    chk("zero_done_pulse", 64'(done), 64'h0);

    // Max 26-bit value
    runConv(26'd67108863, cyc, busyCnt);
    chk("max_latency", 64'(cyc), 64'd26);
    chk("max_busy_cycles", 64'(busyCnt), 64'd26);
    chk("max_bcd", 64'(bcd_out), 64'h67108863);
    chkMask("max_mask", 8'h00);
    tick();

    // 1234 with bin_in changed and start pulsed while shifting
    bin_in = 26'd1234; start = 1'b1;
    tick();
    start = 1'b0; bin_in = 26'd9999;
    doneCnt = 0; lastDone = 0;
    for (int c = 1; c <= 60; c++) begin
      start = (c == 5 || c == 20);
      tick();
      if (done) begin doneCnt++; lastDone = c; end
    end
    start = 1'b0;
    chk("mid_done_count", 64'(doneCnt), 64'd1);
    chk("mid_done_cycle", 64'(lastDone), 64'd26);
    chk("mid_bcd", 64'(bcd_out), 64'h00001234);
    chk("mid_idle_after", 64'(busy), 64'h0);
    chkMask("mid_mask", 8'hF0);

    // Reset mid-conversion of 500
    bin_in = 26'd500; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    rst = 1'b1;
    #1;
    chk("abort_bcd",  64'(bcd_out), 64'h0);
    chk("abort_busy", 64'(busy), 64'h0);
    chk("abort_done", 64'(done), 64'h0);
    chkMask("abort_mask", 8'h00);
    tick();
    rst = 1'b0;
    doneCnt = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (done) doneCnt++;
    end
    chk("abort_no_done", 64'(doneCnt), 64'd0);
    runConv(26'd42, cyc, busyCnt);
    chk("after_abort_latency", 64'(cyc), 64'd26);
    chk("after_abort_bcd", 64'(bcd_out), 64'h00000042);
    chkMask("after_abort_mask", 8'hFC);
    tick();

    // Start held high: back-to-back conversions every 27 cycles
    bin_in = 26'd7; start = 1'b1;
    for (int c = 1; c <= 85; c++) begin
      tick();
      if (done) begin
        doneAt.push_back(c);
        chk("held_bcd", 64'(bcd_out), 64'h00000007);
        chkMask("held_mask", 8'hFE);
      end
    end
    start = 1'b0;
    chk("held_done_count", 64'(doneAt.size()), 64'd3);
    if (doneAt.size() == 3) begin
      chk("held_first",  64'(doneAt[0]), 64'd27);
      chk("held_period1", 64'(doneAt[1] - doneAt[0]), 64'd27);
      chk("held_period2", 64'(doneAt[2] - doneAt[1]), 64'd27);
    end
    for (int c = 0; c < 30; c++) tick();
    chk("held_drain_idle", 64'(busy), 64'h0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
